// File: rtl/ps2_rx.sv
// ps2_rx: filtered PS/2 frame receiver with E0/F0/E1 prefix folding and an event FIFO.
// Optional macro PS2_RX_TIMEOUT_EN enables the inter-edge frame timeout. Revision 1.0.
`default_nettype none

module ps2_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       valid,
  input  logic       rd,
  output logic [7:0] code,
  output logic       ext,
  output logic       rel,
  output logic       ovf,
  output logic       ferr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [7:0]  r_filt;
  logic        r_fclk;
  logic        w_fall;
  logic        w_bit;
  logic        w_to;
  logic [1:0]  r_state, w_state_nxt;
  logic [7:0]  r_sh;
  logic [2:0]  r_cnt;
  logic        r_par;
  logic        w_accept, w_err;
  logic        r_acc, r_ferr;
  logic [7:0]  r_byte;
  logic        r_pext, r_prel;
  logic [2:0]  r_disc;
  logic        w_prefix, w_push, w_pop, w_wr, w_empty, w_full;
  logic [AW:0] r_wptr, r_rptr;
  logic        r_ovf;
  logic [9:0]  r_mem [FIFO_DEPTH];
  logic [9:0]  w_head;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_filt <= 8'hFF;
      r_fclk <= 1'b1;
    end else if (ce) begin
      r_filt <= {r_filt[6:0], ps2[0]};
      if (r_filt == 8'hFF)      r_fclk <= 1'b1;
      else if (r_filt == 8'h00) r_fclk <= 1'b0;
    end
  end

  assign w_fall = ce & r_fclk & (r_filt == 8'h00);
  assign w_bit  = ps2[1];

`ifdef PS2_RX_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= 16'd0;
    end else if (ce) begin
      if (r_state == S_IDLE || w_fall || w_to) r_to_cnt <= 16'd0;
      else                                     r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign w_to = ce & (r_state != S_IDLE) & (r_to_cnt == 16'(TIMEOUT));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT;
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_to) begin
      w_state_nxt = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_bit) w_state_nxt = S_DATA;
        S_DATA:   if (r_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept = 1'b0;
    w_err    = w_to;
    if (w_fall && !w_to) begin
      case (r_state)
        S_IDLE: w_err = w_bit;
        S_STOP: begin
          w_accept = w_bit & (^{r_sh, r_par});
          w_err    = ~w_accept;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sh   <= 8'h00;
      r_cnt  <= 3'd0;
      r_par  <= 1'b0;
      r_acc  <= 1'b0;
      r_byte <= 8'h00;
      r_ferr <= 1'b0;
    end else begin
      r_acc  <= w_accept;
      r_ferr <= w_err;
      if (w_accept) r_byte <= r_sh;
      if (w_fall && !w_to) begin
        case (r_state)
          S_IDLE:   r_cnt <= 3'd0;
          S_DATA: begin
            r_sh  <= {w_bit, r_sh[7:1]};
            r_cnt <= r_cnt + 3'd1;
          end
          S_PARITY: r_par <= w_bit;
          default: ;
        endcase
      end
    end
  end

  // E1 opens the Pause sequence: its 7 trailing bytes never become events.
  assign w_prefix = (r_byte == 8'hE0) | (r_byte == 8'hF0) | (r_byte == 8'hE1);
  assign w_push   = r_acc & (r_disc == 3'd0) & ~w_prefix;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pext <= 1'b0;
      r_prel <= 1'b0;
      r_disc <= 3'd0;
    end else if (r_acc) begin
      if (r_disc != 3'd0)        r_disc <= r_disc - 3'd1;
      else if (r_byte == 8'hE0)  r_pext <= 1'b1;
      else if (r_byte == 8'hF0)  r_prel <= 1'b1;
      else if (r_byte == 8'hE1)  r_disc <= 3'd7;
      else begin
        r_pext <= 1'b0;
        r_prel <= 1'b0;
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) & (r_wptr[AW] != r_rptr[AW]);
  assign w_pop   = rd & ~w_empty;
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {r_pext, r_prel, r_byte};
  end

  assign w_head = r_mem[r_rptr[AW-1:0]];
  assign valid  = ~w_empty;
  assign code   = valid ? w_head[7:0] : 8'h00;
  assign ext    = valid & w_head[9];
  assign rel    = valid & w_head[8];
  assign ovf    = r_ovf;
  assign ferr   = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed self-checking bench for ps2_rx.
`default_nettype none

module tb_ps2_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b1;
  logic       rd    = 1'b0;
  logic [1:0] ps2   = 2'b11;
  logic       valid, ext, rel, ovf, ferr;
  logic [7:0] code;

  ps2_rx #(.FIFO_DEPTH(4), .TIMEOUT(50)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2(ps2), .valid(valid), .rd(rd),
    .code(code), .ext(ext), .rel(rel), .ovf(ovf), .ferr(ferr)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   ferr_hi = 0;
  int   valid_rise_cyc = -1;
  logic prev_valid = 1'b0;
  int   fall_cyc = 0;
  logic [7:0] head_at_pop = 8'h00;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (ferr === 1'b1) ferr_hi++;
    if (valid === 1'b1 && prev_valid !== 1'b1) valid_rise_cyc = cyc;
    prev_valid = valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // One bit cell: data set up while clock is high, 12-cycle halves.
  task automatic send_bit(input logic b, input bit pop_on_push);
    @(negedge clock);
    ps2[1] = b;
    ps2[0] = 1'b1;
    repeat (12) @(negedge clock);
    ps2[0]   = 1'b0;
    fall_cyc = cyc;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (pop_on_push) begin
        if (i == 9) begin
          head_at_pop = code;
          rd = 1'b1;
        end else if (i == 10) begin
          rd = 1'b0;
        end
      end
    end
    ps2[0] = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit pop_on_push);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit((~^d) ^ bad_par, 1'b0);
    send_bit(1'b1, pop_on_push);
    repeat (4) @(negedge clock);
  endtask

  task automatic pop();
    @(negedge clock);
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    rd    = 1'b0;
    ps2   = 2'b11;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_chk++; if (code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h expected 00", code); end
    n_chk++; if (ext !== 1'b0)   begin n_fail++; $display("FAIL reset_ext: got %b expected 0", ext); end
    n_chk++; if (rel !== 1'b0)   begin n_fail++; $display("FAIL reset_rel: got %b expected 0", rel); end
    n_chk++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_chk++; if (ferr !== 1'b0)  begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
  endtask

  task automatic test_single();
    int lat;
    valid_rise_cyc = -1;
    send_frame(8'h1C, 1'b0, 1'b0);
    // 8 ce cycles to fill the filter with zeros, then the edge, then push.
    lat = valid_rise_cyc - fall_cyc;
    n_chk++; if (lat < 9 || lat > 10) begin n_fail++; $display("FAIL single_latency: got %0d expected 9..10", lat); end
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", valid); end
    n_chk++; if (code !== 8'h1C) begin n_fail++; $display("FAIL single_code: got %h expected 1c", code); end
    n_chk++; if ({ext, rel} !== 2'b00) begin n_fail++; $display("FAIL single_flags: got %b expected 00", {ext, rel}); end
    pop();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b expected 0", valid); end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    n_chk++; if (code !== 8'h75 || valid !== 1'b1) begin n_fail++; $display("FAIL prefix_code: got %b/%h expected 1/75", valid, code); end
    n_chk++; if ({ext, rel} !== 2'b11) begin n_fail++; $display("FAIL prefix_flags: got %b expected 11", {ext, rel}); end
    pop();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL prefix_single_event: got %b expected 0", valid); end
    send_frame(8'h75, 1'b0, 1'b0);
    n_chk++; if ({valid, code, ext, rel} !== {1'b1, 8'h75, 2'b00}) begin
      n_fail++; $display("FAIL prefix_cleared: got %b/%h/%b%b expected 1/75/00", valid, code, ext, rel);
    end
    pop();
  endtask

  task automatic test_errors();
    int h;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    h = ferr_hi;
    send_frame(8'h1C, 1'b1, 1'b0);
    n_chk++; if (ferr_hi - h !== 1) begin n_fail++; $display("FAIL parity_ferr: got %0d cycles expected 1", ferr_hi - h); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL parity_no_event: got %b expected 0", valid); end
    h = ferr_hi;
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 1'b0);
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL pause_no_event: got %b expected 0", valid); end
    n_chk++; if (ferr_hi !== h) begin n_fail++; $display("FAIL pause_no_ferr: got %0d expected %0d", ferr_hi, h); end
    send_frame(8'h29, 1'b0, 1'b0);
    n_chk++; if ({valid, code, ext, rel} !== {1'b1, 8'h29, 2'b00}) begin
      n_fail++; $display("FAIL after_pause: got %b/%h/%b%b expected 1/29/00", valid, code, ext, rel);
    end
    pop();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 4; i++) send_frame(codes[i], 1'b0, 1'b0);
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b expected 0", ovf); end
    send_frame(codes[4], 1'b0, 1'b0);
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (valid !== 1'b1 || code !== codes[i]) begin
        n_fail++; $display("FAIL ovf_read%0d: got %b/%h expected 1/%h", i, valid, code, codes[i]);
      end
      pop();
    end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", valid); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4];
    exp = '{8'h1E, 8'h26, 8'h25, 8'h45};
    do_reset();
    send_frame(8'h16, 1'b0, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b0);
    send_frame(8'h26, 1'b0, 1'b0);
    send_frame(8'h25, 1'b0, 1'b0);
    send_frame(8'h45, 1'b0, 1'b1);
    n_chk++; if (head_at_pop !== 8'h16) begin n_fail++; $display("FAIL pushpop_head: got %h expected 16", head_at_pop); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf: got %b expected 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (valid !== 1'b1 || code !== exp[i]) begin
        n_fail++; $display("FAIL pushpop_read%0d: got %b/%h expected 1/%h", i, valid, code, exp[i]);
      end
      pop();
    end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_drained: got %b expected 0", valid); end
  endtask

`ifdef PS2_RX_TIMEOUT_EN
  task automatic test_timeout();
    int h;
    h = ferr_hi;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 200 && ferr_hi == h; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    n_chk++; if (ferr_hi - h !== 1) begin n_fail++; $display("FAIL timeout_ferr: got %0d cycles expected 1", ferr_hi - h); end
    send_frame(8'h5A, 1'b0, 1'b0);
    n_chk++; if (valid !== 1'b1 || code !== 8'h5A) begin
      n_fail++; $display("FAIL timeout_recover: got %b/%h expected 1/5a", valid, code);
    end
    pop();
  endtask
`endif

  task automatic test_mid_reset();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1 == 1'b0);
    send_bit(1'b1, 1'b0);
    do_reset();
    n_chk++; if (valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got %b/%b expected 0/0", valid, ovf);
    end
    send_frame(8'h5A, 1'b0, 1'b0);
    n_chk++; if (valid !== 1'b1 || code !== 8'h5A) begin
      n_fail++; $display("FAIL midreset_frame: got %b/%h expected 1/5a", valid, code);
    end
    pop();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale: got %b expected 0", valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_errors();
    test_overflow();
    test_full_push_pop();
`ifdef PS2_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_rx.md
# ps2_rx

Front-end PS/2 receiver that sits directly upstream of the keyboard matrix decoder. It filters the raw PS/2 clock and data lines and assembles 11-bit frames, checking start, odd parity and stop bits. It folds the E0/F0 prefix bytes into flags and queues complete key events in a small FIFO. The decoder pops events one at a time, so a burst of bytes from the keyboard cannot be lost while the decoder is busy.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of event entries; power of two, 2..16.
- TIMEOUT, 2000, ce ticks allowed between two filtered clock falling edges inside a frame.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  sampling enable; all PS/2 sampling, filtering and timeout counting advance only on cycles with ce=1.
- ps2  in  2  ps2[0] = PS/2 clock line, ps2[1] = PS/2 data line.
- valid  out  1  FIFO not empty; head event is presented on code/ext/rel.
- rd  in  1  pop strobe; honoured only when valid=1.
- code  out  8  scancode of the head event.
- ext  out  1  head event was preceded by E0.
- rel  out  1  head event was preceded by F0 (key release).
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- ferr  out  1  one-clock pulse on a start, parity or stop error, or on a timeout.

## Operation
- Clock filter: 8-bit shift of ps2[0] on each ce.
  - All ones sets the filtered clock high; all zeros sets it low.
  - A high-to-low transition of the filtered clock is a falling edge. ps2[1] is registered on that same ce and used as the bit value.
- Frame FSM, advanced on falling edges:
  - IDLE: bit 0 moves to DATA; bit 1 stays in IDLE and pulses ferr.
  - DATA: shifts 8 bits LSB first, then moves to PARITY.
  - PARITY: moves to STOP.
  - STOP: the byte is accepted when the stop bit is 1 and data^parity has odd weight (XOR of all nine bits = 1). Any other case pulses ferr. The FSM returns to IDLE either way.
- Prefix stage, on each accepted byte:
  - E0 sets pend_ext. F0 sets pend_rel. Neither produces an event.
  - E1 loads a discard counter with 7; the next 7 accepted bytes are dropped (Pause sequence). No event is produced.
  - Any other byte pushes {pend_ext, pend_rel, byte} and clears both pending flags.
- FIFO entries are 10 bits. The head entry drives code/ext/rel combinationally from storage.
- Push while full: the event is dropped and ovf is set.
- Push and pop in the same clock while full: both complete, and occupancy stays at FULL.
- Pop while empty: ignored.
- ovf clears only on reset.
- Pointers wrap modulo FIFO_DEPTH; one extra pointer bit distinguishes full from empty.

## Timing
- Reset values: valid=0, code=8'h00, ext=0, rel=0, ovf=0, ferr=0.
  - FSM in IDLE, filter and filtered clock all ones, pending flags and discard counter cleared, FIFO empty.
  - Reset acts immediately on assertion, including mid-frame; a partial frame is discarded.
- Byte acceptance happens on the ce cycle of the stop-bit edge (cycle N).
- The push occurs on clock N+1; valid=1 and the new code are visible from clock N+2.
- rd sampled high on clock M (with valid=1) advances the read pointer. The next entry, or valid=0, is visible from clock M+1.
- ferr is high for exactly one clock, the one after the error is detected.
- Outside ce cycles, only FIFO push/pop and the outputs update.

## Configuration
- PS2_RX_TIMEOUT_EN defined:
  - A 16-bit counter increments on every ce while the FSM is not IDLE and clears on each falling edge.
  - On reaching TIMEOUT, the FSM returns to IDLE, ferr pulses and the partial byte is discarded. Pending prefix flags are kept.
- PS2_RX_TIMEOUT_EN undefined:
  - There is no counter and the TIMEOUT parameter is unused.
  - A truncated frame is resynchronised only by subsequent edges or by reset.

## Test plan
- Send frame for 8'h1C (odd parity bit 0) -> valid rises two clocks after stop, code=8'h1C, ext=0, rel=0. Pulse rd -> valid=0 next clock.
- Send E0,F0,75 -> exactly one event: code=8'h75, ext=1, rel=1. Pending flags are then clear, and a following 8'h75 gives ext=0, rel=0.
- Send 8'h1C with wrong parity -> no event, ferr pulses once. Send E1,14,77,E1,F0,14,F0,77 -> no events. A following 8'h29 yields code=8'h29.
- FIFO_DEPTH=4, no reads: send 5 codes 16,1E,26,25,2E -> ovf=1 after the 5th. Reads return 16,1E,26,25, then valid=0.
- Full FIFO, assert rd on the push clock of a new code 8'h45 -> ovf stays 0 and the 4th read returns 8'h45.
- PS2_RX_TIMEOUT_EN, TIMEOUT=50: stop after 4 data bits and wait 50 ce -> ferr pulses, FSM idle. A complete 8'h5A frame is then received correctly. Asserting reset mid-frame yields valid=0 and no stale event.
